// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side inputs, forwarding sources and EX-side outputs for id_ex_operand_stage.
// The stage uses the slave modport; the driver of ID/forward inputs uses master.
interface id_ex_operand_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          id_alu_src;
  logic [2:0]    id_alu_ctrl;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;
  logic          id_uses_rt;
  logic          stall;
  logic          flush;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_ctrl;
  logic [DW-1:0] store_data;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic [RW-1:0] ex_rd;
  logic          load_use_hazard;

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_uses_rt, stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    output alu_a, alu_b, alu_ctrl, store_data, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, load_use_hazard
  );

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_uses_rt, stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    input  alu_a, alu_b, alu_ctrl, store_data, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, load_use_hazard
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand select and load-use detection feeding the ALU.
// Define ID_EX_FORWARDING_EN to forward from EX/MEM and MEM/WB; otherwise any pending write stalls.
module id_ex_operand_stage #(
  parameter int          DW          = 32,
  parameter int          RW          = 5,
  parameter logic [2:0]  BUBBLE_CTRL = 3'b010
) (
  input  logic                   clk,
  input  logic                   reset,
  id_ex_operand_stage_if.slave   bus
);

  logic          valid_q, valid_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          alu_src_q, alu_src_d;
  logic [2:0]    alu_ctrl_q, alu_ctrl_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= BUBBLE_CTRL;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  // Flush beats stall; an empty ID slot also loads a bubble.
  always_comb begin
    valid_d      = valid_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    alu_src_d    = alu_src_q;
    alu_ctrl_d   = alu_ctrl_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (bus.flush || (!bus.stall && !bus.id_valid)) begin
      valid_d      = 1'b0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      alu_src_d    = 1'b0;
      alu_ctrl_d   = BUBBLE_CTRL;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d      = 1'b1;
      rs_data_d    = bus.id_rs_data;
      rt_data_d    = bus.id_rt_data;
      imm_d        = bus.id_imm;
      rs_d         = bus.id_rs;
      rt_d         = bus.id_rt;
      rd_d         = bus.id_rd;
      alu_src_d    = bus.id_alu_src;
      alu_ctrl_d   = bus.id_alu_ctrl;
      reg_write_d  = bus.id_reg_write;
      mem_read_d   = bus.id_mem_read;
      mem_write_d  = bus.id_mem_write;
      mem_to_reg_d = bus.id_mem_to_reg;
    end
  end

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          pending_write_hazard;

`ifdef ID_EX_FORWARDING_EN
  // r0 is hard-wired zero, so a write to it must never be forwarded.
  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rs_q))
      fwd_rs = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rs_q))
      fwd_rs = bus.memwb_data;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rt_q))
      fwd_rt = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rt_q))
      fwd_rt = bus.memwb_data;
  end

  assign pending_write_hazard = 1'b0;
`else
  logic fwd_unused;
  assign fwd_unused = ^{bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                        bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data};
  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
  // Without forwarding, any result still in flight must be waited out upstream.
  assign pending_write_hazard = reg_write_q;
`endif

  logic src_match;
  assign src_match = (rd_q == bus.id_rs) || (bus.id_uses_rt && (rd_q == bus.id_rt));

  assign bus.load_use_hazard = valid_q && (mem_read_q || pending_write_hazard) &&
                               (rd_q != '0) && src_match;

  assign bus.alu_a         = fwd_rs;
  assign bus.alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign bus.store_data    = fwd_rt;
  assign bus.alu_ctrl      = alu_ctrl_q;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_mem_to_reg = mem_to_reg_q;
  assign bus.ex_rd         = rd_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations adapt to ID_EX_FORWARDING_EN.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  id_ex_operand_stage_if #(.DW(32), .RW(5)) bus ();

  id_ex_operand_stage #(.DW(32), .RW(5), .BUBBLE_CTRL(3'b010)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs, rt, rd;
    logic        src;
    logic [2:0]  ctl;
    logic [4:0]  xr;
    logic        xw;
    logic [31:0] xd;
    logic [4:0]  wr;
    logic        ww;
    logic [31:0] wd;
    logic [31:0] ea, eb, es;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_alu_src = 0;
    bus.id_alu_ctrl = 3'b010; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.id_mem_write = 0; bus.id_mem_to_reg = 0; bus.id_uses_rt = 0;
    bus.stall = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.id_valid = 1; bus.id_rs_data = v.rs_d; bus.id_rt_data = v.rt_d;
    bus.id_imm = v.imm; bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_rd = v.rd;
    bus.id_alu_src = v.src; bus.id_alu_ctrl = v.ctl; bus.id_reg_write = 1;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    bus.id_uses_rt = 1;
    bus.exmem_rd = v.xr; bus.exmem_reg_write = v.xw; bus.exmem_result = v.xd;
    bus.memwb_rd = v.wr; bus.memwb_reg_write = v.ww; bus.memwb_data = v.wd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 0;
    clear_inputs();

    // add r5,r1,r2 with progressively different forward sources
    vecs[0] = '{32'h10, 32'h20, 32'h0, 5'd1, 5'd2, 5'd5, 1'b0, 3'b010,
                5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
                32'h10, 32'h20, 32'h20};
    vecs[1] = '{32'h10, 32'h20, 32'h0, 5'd1, 5'd2, 5'd5, 1'b0, 3'b010,
                5'd1, 1'b1, 32'hAA, 5'd1, 1'b1, 32'hBB,
                FWD ? 32'hAA : 32'h10, 32'h20, 32'h20};
    vecs[2] = '{32'h10, 32'h20, 32'h0, 5'd1, 5'd2, 5'd5, 1'b0, 3'b010,
                5'd1, 1'b0, 32'hAA, 5'd1, 1'b1, 32'hBB,
                FWD ? 32'hBB : 32'h10, 32'h20, 32'h20};
    // addi r6,r0,7 while EX/MEM "writes" r0
    vecs[3] = '{32'h0, 32'h33, 32'h7, 5'd0, 5'd6, 5'd6, 1'b1, 3'b010,
                5'd0, 1'b1, 32'hFF, 5'd0, 1'b0, 32'h0,
                32'h0, 32'h7, 32'h33};
    // rt matched by both stages: EX/MEM wins
    vecs[4] = '{32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd9, 1'b0, 3'b110,
                5'd2, 1'b1, 32'hCC, 5'd2, 1'b1, 32'hDD,
                32'h1, FWD ? 32'hCC : 32'h2, FWD ? 32'hCC : 32'h2};
    // rs=rt=r3 from MEM/WB, immediate on B
    vecs[5] = '{32'h30, 32'h30, 32'h100, 5'd3, 5'd3, 5'd10, 1'b1, 3'b000,
                5'd4, 1'b1, 32'h44, 5'd3, 1'b1, 32'hEE,
                FWD ? 32'hEE : 32'h30, 32'h100, FWD ? 32'hEE : 32'h30};

    // async reset at power-up, checked before any clock edge
    #2 reset = 1;
    #1;
    chk("rst_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rst_ctrl", {29'b0, bus.alu_ctrl}, 32'd2);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 6; i++) begin
      drive_vec(vecs[i]);
      tick();
      chk($sformatf("v%0d_alu_a", i), bus.alu_a, vecs[i].ea);
      chk($sformatf("v%0d_alu_b", i), bus.alu_b, vecs[i].eb);
      chk($sformatf("v%0d_store", i), bus.store_data, vecs[i].es);
      chk($sformatf("v%0d_rd", i), {27'b0, bus.ex_rd}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_ctrl", i), {29'b0, bus.alu_ctrl}, {29'b0, vecs[i].ctl});
      chk($sformatf("v%0d_valid", i), {31'b0, bus.ex_valid}, 32'd1);
    end
    clear_inputs();

    // mid-stream reset after loading add rs=3 rt=4
    bus.id_valid = 1; bus.id_rs = 3; bus.id_rt = 4; bus.id_rd = 5;
    bus.id_rs_data = 32'h55; bus.id_rt_data = 32'h66; bus.id_reg_write = 1;
    bus.id_alu_ctrl = 3'b110;
    tick();
    chk("pre_rst_valid", {31'b0, bus.ex_valid}, 32'd1);
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("mid_rst_ctrl", {29'b0, bus.alu_ctrl}, 32'd2);
    chk("mid_rst_wr", {31'b0, bus.ex_reg_write}, 32'd0);
    chk("mid_rst_rd", {27'b0, bus.ex_rd}, 32'd0);
    chk("mid_rst_a", bus.alu_a, 32'd0);
    chk("mid_rst_b", bus.alu_b, 32'd0);
    @(negedge clk);
    reset = 0;
    clear_inputs();

    // lw r8 in EX, consumers in ID
    bus.id_valid = 1; bus.id_rd = 8; bus.id_mem_read = 1; bus.id_reg_write = 1;
    bus.id_mem_to_reg = 1;
    tick();
    bus.id_valid = 0; bus.id_rs = 8; bus.id_rt = 0; bus.id_uses_rt = 0;
    #1 chk("lu_rs", {31'b0, bus.load_use_hazard}, 32'd1);
    bus.id_rs = 1; bus.id_rt = 8; bus.id_uses_rt = 0;
    #1 chk("lu_rt_unused", {31'b0, bus.load_use_hazard}, 32'd0);
    bus.id_uses_rt = 1;
    #1 chk("lu_rt_used", {31'b0, bus.load_use_hazard}, 32'd1);
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("lu_flush_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("lu_flush_haz", {31'b0, bus.load_use_hazard}, 32'd0);
    chk("lu_flush_mr", {31'b0, bus.ex_mem_read}, 32'd0);

    // ALU producer in EX: a hazard only when nothing forwards
    bus.id_valid = 1; bus.id_rd = 9; bus.id_mem_read = 0; bus.id_reg_write = 1;
    bus.id_rs = 0; bus.id_rt = 0;
    tick();
    bus.id_valid = 0; bus.id_rs = 9;
    #1 chk("alu_dep_haz", {31'b0, bus.load_use_hazard}, FWD ? 32'd0 : 32'd1);
    clear_inputs();

    // stall holds through changing ID inputs
    bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 7;
    bus.id_rs_data = 32'h111; bus.id_rt_data = 32'h222; bus.id_imm = 32'h333;
    bus.id_alu_ctrl = 3'b110; bus.id_reg_write = 1;
    tick();
    bus.stall = 1;
    for (int c = 0; c < 3; c++) begin
      bus.id_valid = c[0]; bus.id_rs_data = 32'h900 + c; bus.id_rt_data = 32'hA00 + c;
      bus.id_rd = 5'(20 + c); bus.id_alu_src = 1; bus.id_alu_ctrl = 3'b001;
      tick();
      chk($sformatf("stall%0d_a", c), bus.alu_a, 32'h111);
      chk($sformatf("stall%0d_b", c), bus.alu_b, 32'h222);
      chk($sformatf("stall%0d_rd", c), {27'b0, bus.ex_rd}, 32'd7);
      chk($sformatf("stall%0d_ctrl", c), {29'b0, bus.alu_ctrl}, 32'd6);
      chk($sformatf("stall%0d_valid", c), {31'b0, bus.ex_valid}, 32'd1);
    end
    bus.flush = 1;
    tick();
    chk("sf_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("sf_ctrl", {29'b0, bus.alu_ctrl}, 32'd2);
    chk("sf_rd", {27'b0, bus.ex_rd}, 32'd0);
    chk("sf_wr", {31'b0, bus.ex_reg_write}, 32'd0);
    bus.stall = 0; bus.flush = 0;

    // empty ID slot loads a bubble
    bus.id_valid = 1; bus.id_rd = 12; bus.id_reg_write = 1; bus.id_mem_write = 1;
    tick();
    chk("load_mw", {31'b0, bus.ex_mem_write}, 32'd1);
    bus.id_valid = 0;
    tick();
    chk("idle_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("idle_mw", {31'b0, bus.ex_mem_write}, 32'd0);
    chk("idle_wr", {31'b0, bus.ex_reg_write}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the 32-bit ALU in the MIPS pipeline.
- Captures decoded operands and control from ID.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Selects register or immediate for operand B, and drives the ALU a/b/ALUControl inputs plus store data and write-back control toward MEM.

Parameters:
- DW, 32, datapath width (ALU operands, immediate, forwarded data)
- RW, 5, register-address width
- BUBBLE_CTRL, 3'b010, ALU control value loaded for a bubble (add)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a real instruction this cycle
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  sign-/zero-extended immediate
- id_rs, id_rt, id_rd  in  RW  source regs; id_rd is the resolved destination
- id_alu_src  in  1  1 = operand B from immediate
- id_alu_ctrl  in  3  ALU control code
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  each, control bits
- id_uses_rt  in  1  instruction in ID reads rt
- stall  in  1  hold all stage registers
- flush  in  1  load bubble into stage
- exmem_reg_write  in  1; exmem_rd  in  RW; exmem_result  in  DW  EX/MEM forward source
- memwb_reg_write  in  1; memwb_rd  in  RW; memwb_data  in  DW  MEM/WB forward source
- alu_a, alu_b  out  DW  ALU operands
- alu_ctrl  out  3  ALU control
- store_data  out  DW  forwarded rt for stores
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  each, registered control
- ex_rd  out  RW  registered destination
- load_use_hazard  out  1  request to upstream hazard controller

Behaviour:
- Registers: valid, rs_data, rt_data, imm, rs, rt, rd, alu_src, alu_ctrl, and the four control bits.
- Reset (async, immediate):
  - all data/address registers 0
  - control bits 0
  - valid 0
  - alu_ctrl = BUBBLE_CTRL
- Update priority on each rising clk: reset > flush > stall > load.
  - flush=1: load bubble (same values as reset), regardless of stall.
  - stall=1, flush=0: hold all registers.
  - Otherwise, if id_valid=1: capture all id_* inputs.
  - Otherwise (id_valid=0): load bubble.
- Latency: one cycle ID→EX. Forwarding, operand select and hazard detection are combinational on registered state plus current inputs.
- Forward A (source rs):
  - If exmem_reg_write && exmem_rd!=0 && exmem_rd==rs → exmem_result.
  - Else if memwb_reg_write && memwb_rd!=0 && memwb_rd==rs → memwb_data.
  - Else rs_data. EX/MEM has priority over MEM/WB.
- Forward B (source rt): same rule → fwd_rt.
- Operand outputs:
  - alu_a = forward A
  - alu_b = alu_src ? imm : fwd_rt
  - store_data = fwd_rt always
- Register 0 is never forwarded; the register-file value (0) is used.
- Bubble: all write/memory control bits 0, so a bubble produces no architectural effect. ALU output for a bubble is don't-care.
- load_use_hazard = valid && ex_mem_read && rd!=0 && (rd==id_rs || (id_uses_rt && rd==id_rt)).
  - Upstream responds with flush=1 to this stage and holds IF/ID for one cycle.
  - This stage does not self-stall.
- Reset mid-stream discards the captured instruction; load_use_hazard deasserts immediately (valid=0).
- Forwarding inputs are sampled combinationally, so their changes propagate to alu_a/alu_b in the same cycle. Forwarding does not depend on stall.

Optional Feature:
- Macro: ID_EX_FORWARDING_EN
- Defined: forwarding as above.
- Undefined:
  - alu_a = rs_data
  - store_data = rt_data
  - alu_b = alu_src ? imm : rt_data
  - exmem_*/memwb_* inputs ignored
  - load_use_hazard extended to any valid && reg_write && rd!=0 match on rs/rt, so software-free correctness relies on upstream stalling.

Test Plan:
- Reset while loaded with add (rs=3, rt=4) → next sample: ex_valid=0, alu_ctrl=3'b010, ex_reg_write=0, ex_rd=0, all data 0, without waiting for clk.
- Load add r5,r1,r2 (rs_data=0x10, rt_data=0x20), no forward matches → one cycle later alu_a=0x10, alu_b=0x20, alu_ctrl=3'b010, ex_rd=5.
- Same instruction with exmem_rd=1 (exmem_result=0xAA) and memwb_rd=1 (memwb_data=0xBB), both write-enabled → alu_a=0xAA. Drop exmem_reg_write → alu_a=0xBB.
- addi r6,r0,0x7 (alu_src=1, imm=7) with exmem_rd=0 write-enabled, exmem_result=0xFF → alu_a=0 (no forward from r0), alu_b=7.
- EX holds lw r8 (mem_read=1, rd=8); ID has id_rs=8 → load_use_hazard=1. Assert flush → next cycle ex_valid=0, hazard=0. id_rt=8 with id_uses_rt=0 → hazard=0.
- stall=1 for 3 cycles with changing id_* → outputs unchanged. stall=1 and flush=1 together → bubble loaded.
